// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// registers the returned word into IF/ID; handles stall, redirect/flush, traps and halt.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_W     = 10,
   parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Stall,
   input  logic              BranchTaken,
   input  logic [31:0]       BranchTarget,
   input  logic [31:0]       Instruction,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [31:0]       PC,
   output logic [31:0]       InstrOut,
   output logic [31:0]       PCOut,
   output logic              Valid,
   output logic              Halted,
   output logic              Misaligned
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt, instr_nxt, pcout_nxt;
   logic        valid_nxt, halted_nxt, mis_nxt;
   logic        redirect, bad_target;

   assign MemAddress = PC[ADDR_W+1:2];
   assign redirect   = BranchTaken;
   assign bad_target = BranchTaken && (BranchTarget[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_BOOT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: state_nxt = ST_RUN;
         ST_RUN: begin
            if (bad_target)
               state_nxt = ST_HALTED;
            else if (!redirect && !Stall && Instruction == HALT_INSTR)
               state_nxt = ST_HALTED;
         end
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_BOOT;
      endcase
   end

   // Next values of the datapath registers; default is to hold.
   always_comb begin
      pc_nxt     = PC;
      instr_nxt  = InstrOut;
      pcout_nxt  = PCOut;
      valid_nxt  = Valid;
      halted_nxt = Halted;
      mis_nxt    = Misaligned;
      case (state)
         ST_RUN: begin
            if (bad_target) begin
               mis_nxt    = 1'b1;
               halted_nxt = 1'b1;
               instr_nxt  = NOP_INSTR;
               valid_nxt  = 1'b0;
            end else if (redirect) begin
               // Flush the wrong-path word, even when decode is stalling.
               pc_nxt    = BranchTarget;
               instr_nxt = NOP_INSTR;
               valid_nxt = 1'b0;
            end else if (!Stall) begin
               instr_nxt = Instruction;
               pcout_nxt = PC;
               valid_nxt = 1'b1;
               pc_nxt    = PC + 32'd4;
            end
         end
         ST_HALTED: begin
            halted_nxt = 1'b1;
            instr_nxt  = NOP_INSTR;
            valid_nxt  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC         <= RESET_PC;
         InstrOut   <= NOP_INSTR;
         PCOut      <= 32'h0;
         Valid      <= 1'b0;
         Halted     <= 1'b0;
         Misaligned <= 1'b0;
      end else begin
         PC         <= pc_nxt;
         InstrOut   <= instr_nxt;
         PCOut      <= pcout_nxt;
         Valid      <= valid_nxt;
         Halted     <= halted_nxt;
         Misaligned <= mis_nxt;
      end
   end

endmodule
